// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative 32-bit unsigned MUL/MULHU/DIVU/REMU with valid/ready writeback
// Define MULDIV_DIV_EN to build the divider; without it divide ops return op_err in one cycle.
module muldiv_unit #(
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [31:0]           rs1_val,
  input  logic [31:0]           rs2_val,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  kill,
  output logic                  busy,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [REG_ADDR_W-1:0] wb_rd_addr,
  output logic [31:0]           wb_data,
  output logic                  op_err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state;
  logic        sel_hi;
  logic [63:0] prod;
  logic [31:0] opb;
  logic [4:0]  cnt;
  logic [32:0] mul_sum;
  logic [63:0] step_next;
  logic [31:0] result_next;

`ifdef MULDIV_DIV_EN
  logic        is_div;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_sub;

  // prod[63:32] is the partial remainder, prod[31:0] shifts the dividend out and quotient in
  always_comb begin
    div_shift = {prod[63:32], prod[31]};
    div_ge    = (div_shift >= {1'b0, opb});
    div_sub   = div_shift[31:0] - opb;
  end

  assign op_err = 1'b0;
`endif

  // prod[63:32] accumulates the product, prod[31:0] shifts the multiplier out
  always_comb begin
    mul_sum   = {1'b0, prod[63:32]} + {1'b0, (prod[0] ? opb : 32'd0)};
    step_next = {mul_sum, prod[31:1]};
`ifdef MULDIV_DIV_EN
    if (is_div) begin
      step_next = {(div_ge ? div_sub : div_shift[31:0]), prod[30:0], div_ge};
    end
`endif
    result_next = sel_hi ? step_next[63:32] : step_next[31:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      wb_valid   <= 1'b0;
      wb_data    <= 32'd0;
      wb_rd_addr <= '0;
      cnt        <= 5'd0;
      prod       <= 64'd0;
      opb        <= 32'd0;
      sel_hi     <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div     <= 1'b0;
`else
      op_err     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sel_hi     <= op[0];
            wb_rd_addr <= rd_addr;
            busy       <= 1'b1;
            cnt        <= 5'd0;
`ifdef MULDIV_DIV_EN
            is_div <= op[1];
            prod   <= {32'd0, (op[1] ? rs1_val : rs2_val)};
            opb    <= op[1] ? rs2_val : rs1_val;
            state  <= S_RUN;
`else
            prod <= {32'd0, rs2_val};
            opb  <= rs1_val;
            if (op[1]) begin
              state    <= S_DONE;
              wb_valid <= 1'b1;
              wb_data  <= 32'd0;
              op_err   <= 1'b1;
            end else begin
              state  <= S_RUN;
              op_err <= 1'b0;
            end
`endif
          end
        end
        S_RUN: begin
          if (kill) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            prod <= step_next;
            cnt  <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              state    <= S_DONE;
              wb_valid <= 1'b1;
              wb_data  <= result_next;
            end
          end
        end
        S_DONE: begin
          if (kill || wb_ready) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            wb_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [2:0]  rd_addr;
  logic        kill;
  logic        busy;
  logic        wb_valid;
  logic        wb_ready;
  logic [2:0]  wb_rd_addr;
  logic [31:0] wb_data;
  logic        op_err;

  int n_assert = 0;
  int n_fail   = 0;
  int lat;

  muldiv_unit #(.REG_ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_addr(rd_addr), .kill(kill),
    .busy(busy), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd_addr(wb_rd_addr), .wb_data(wb_data), .op_err(op_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op at edge E0 and count edges after E0 until wb_valid rises
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] rd, output int n);
    op = o; rs1_val = a; rs2_val = b; rd_addr = rd; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!wb_valid && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic chk_div(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    run_op(o, a, b, 3'd1, lat);
`ifdef MULDIV_DIV_EN
    chk({tag, "_lat"}, lat, 32);
    chk({tag, "_data"}, wb_data, exp);
    chk({tag, "_err"}, op_err, 1'b0);
`else
    chk({tag, "_lat"}, lat, 0);
    chk({tag, "_data"}, wb_data, 32'd0);
    chk({tag, "_err"}, op_err, 1'b1);
    chk({tag, "_unused"}, exp, exp);
`endif
    tick();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; rs1_val = '0; rs2_val = '0;
    rd_addr = '0; kill = 1'b0; wb_ready = 1'b1;
    tick(); tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", wb_valid, 1'b0);
    chk("rst_data", wb_data, 32'd0);
    chk("rst_addr", wb_rd_addr, 3'd0);
    chk("rst_err", op_err, 1'b0);
    rst_n = 1'b1;
    tick();

    run_op(2'b00, 32'h0001_0003, 32'h0002_0005, 3'd5, lat);
    chk("mul_lat", lat, 32);
    chk("mul_data", wb_data, 32'h000B_000F);
    chk("mul_addr", wb_rd_addr, 3'd5);
    chk("mul_err", op_err, 1'b0);
    tick();
    chk("mul_hs_valid", wb_valid, 1'b0);
    chk("mul_hs_busy", busy, 1'b0);

    run_op(2'b01, 32'h0001_0003, 32'h0002_0005, 3'd5, lat);
    chk("mulhu_lat", lat, 32);
    chk("mulhu_data", wb_data, 32'h0000_0002);
    tick();

    chk_div("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd14);
    chk_div("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2);
    chk_div("divu_by0", 2'b10, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF);
    chk_div("remu_by0", 2'b11, 32'h0000_1234, 32'd0, 32'h0000_1234);

    // Backpressure: result must hold and a start pulse must not re-latch
    wb_ready = 1'b0;
    run_op(2'b00, 32'h0000_1234, 32'h0000_0010, 3'd3, lat);
    chk("bp_lat", lat, 32);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        op = 2'b01; rs1_val = 32'hDEAD_BEEF; rs2_val = 32'h5; rd_addr = 3'd6; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      chk("bp_valid", wb_valid, 1'b1);
      chk("bp_data", wb_data, 32'h0001_2340);
      chk("bp_addr", wb_rd_addr, 3'd3);
    end
    start = 1'b0;
    wb_ready = 1'b1;
    tick();
    chk("bp_hs_valid", wb_valid, 1'b0);
    chk("bp_hs_busy", busy, 1'b0);
    tick();
    chk("bp_idle_busy", busy, 1'b0);

    // Kill in RUN at cycle 20
    op = 2'b00; rs1_val = 32'd9; rs2_val = 32'd9; rd_addr = 3'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("krun_busy_pre", busy, 1'b1);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("krun_busy", busy, 1'b0);
    chk("krun_valid", wb_valid, 1'b0);
    for (int i = 0; i < 15; i++) tick();
    chk("krun_no_valid", wb_valid, 1'b0);

    // Kill in DONE wins over wb_ready
    run_op(2'b00, 32'd5, 32'd5, 3'd7, lat);
    chk("kdone_lat", lat, 32);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("kdone_valid", wb_valid, 1'b0);
    chk("kdone_busy", busy, 1'b0);

    run_op(2'b00, 32'd3, 32'd4, 3'd0, lat);
    chk("mul3x4_lat", lat, 32);
    chk("mul3x4_data", wb_data, 32'd12);
    chk("mul3x4_addr", wb_rd_addr, 3'd0);
    tick();

    run_op(2'b00, 32'd6, 32'd7, 3'd2, lat);
    chk("mul6x7_data", wb_data, 32'd42);
    chk("mul6x7_err", op_err, 1'b0);
    tick();

    // Reset mid-RUN drops the in-flight op and clears the result
    op = 2'b00; rs1_val = 32'd11; rs2_val = 32'd13; rd_addr = 3'd4; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rstrun_busy", busy, 1'b0);
    chk("rstrun_valid", wb_valid, 1'b0);
    chk("rstrun_data", wb_data, 32'd0);
    for (int i = 0; i < 30; i++) tick();
    chk("rstrun_no_valid", wb_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
